// File: rtl/exec_unit.sv
// 8-bit execute unit: ALU ops complete 1 cycle after start, shifts take n cycles, MUL takes 8 cycles.
// No backpressure: start is sampled only in IDLE and is dropped while busy or done; issue rate is one op per 2 cycles.
module exec_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] datA,
    input  logic [7:0] datB,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       wr_en,
    output logic       write_r0,
    output logic       carry,
    output logic       zero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [3:0]  count_q, count_d;
    logic [7:0]  result_q, result_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic        done_q, done_d;
    logic        wr_en_q, wr_en_d;
    logic        write_r0_q, write_r0_d;
    logic        busy_q, busy_d;

    logic        fin;
    logic [7:0]  fin_res;
    logic        fin_c;
    logic [2:0]  fin_op;
    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic [7:0]  sh_nxt;
    logic        sh_out;
    logic [15:0] prod_nxt;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        count_d    = count_q;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        write_r0_d = 1'b0;
        fin        = 1'b0;
        fin_res    = 8'h00;
        fin_c      = 1'b0;
        fin_op     = op_q;

        sum9     = {1'b0, datA} + {1'b0, datB};
        // The 9-bit difference wraps into bit 8 exactly when A < B.
        diff9    = {1'b0, datA} - {1'b0, datB};
        sh_nxt   = (op_q == OP_SHR) ? {1'b0, acc_q[7:1]} : {acc_q[6:0], 1'b0};
        sh_out   = (op_q == OP_SHR) ? acc_q[0] : acc_q[7];
        prod_nxt = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    fin_op = op;
                    case (op)
                        OP_ADD: begin
                            fin     = 1'b1;
                            fin_res = sum9[7:0];
                            fin_c   = sum9[8];
                        end
                        OP_SUB: begin
                            fin     = 1'b1;
                            fin_res = diff9[7:0];
                            fin_c   = diff9[8];
                        end
                        OP_AND: begin
                            fin     = 1'b1;
                            fin_res = datA & datB;
                        end
                        OP_OR: begin
                            fin     = 1'b1;
                            fin_res = datA | datB;
                        end
                        OP_XOR: begin
                            fin     = 1'b1;
                            fin_res = datA ^ datB;
                        end
                        OP_SHL, OP_SHR: begin
                            if (datB[2:0] == 3'd0) begin
                                fin     = 1'b1;
                                fin_res = datA;
                            end else begin
                                state_d = S_RUN;
                                acc_d   = {8'h00, datA};
                                count_d = {1'b0, datB[2:0]};
                            end
                        end
                        default: begin
                            state_d  = S_RUN;
                            acc_d    = 16'h0000;
                            mcand_d  = {8'h00, datA};
                            mplier_d = datB;
                            count_d  = 4'd8;
                        end
                    endcase
                end
            end
            S_RUN: begin
                count_d = count_q - 4'd1;
                if (op_q == OP_MUL) begin
                    acc_d    = prod_nxt;
                    mcand_d  = {mcand_q[14:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[7:1]};
                    fin_res  = prod_nxt[7:0];
                    fin_c    = |prod_nxt[15:8];
                end else begin
                    acc_d   = {8'h00, sh_nxt};
                    fin_res = sh_nxt;
                    fin_c   = sh_out;
                end
                fin = (count_q == 4'd1);
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Result and flags only ever move on the edge that enters DONE.
        if (fin) begin
            state_d  = S_DONE;
            result_d = fin_res;
            carry_d  = fin_c;
            zero_d   = (fin_res == 8'h00);
            done_d   = 1'b1;
            if (fin_op == OP_AND || fin_op == OP_OR || fin_op == OP_XOR) begin
                write_r0_d = 1'b1;
            end else begin
                wr_en_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= 3'b000;
            acc_q      <= 16'h0000;
            mcand_q    <= 16'h0000;
            mplier_q   <= 8'h00;
            count_q    <= 4'd0;
            result_q   <= 8'h00;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            write_r0_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            count_q    <= count_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            write_r0_q <= write_r0_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign wr_en    = wr_en_q;
    assign write_r0 = write_r0_q;
    assign carry    = carry_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: hand-computed results, flags, strobes and latencies.
module tb_exec_unit;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       r0;
        logic [3:0] lat;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] datA;
    logic [7:0] datB;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       wr_en;
    logic       write_r0;
    logic       carry;
    logic       zero;

    int errors = 0;
    int checks = 0;

    exec_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .datA     (datA),
        .datB     (datB),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .wr_en    (wr_en),
        .write_r0 (write_r0),
        .carry    (carry),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op and watches 14 cycles; inj[i] re-pulses start (ADD 1+1) in cycle i.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] inj,
                          output int done_at, output int done_cnt, output int busy_cnt,
                          output int strobe_cnt, output logic [7:0] r, output logic c,
                          output logic z, output logic we, output logic w0);
        done_at = -1; done_cnt = 0; busy_cnt = 0; strobe_cnt = 0;
        r = 8'h00; c = 1'b0; z = 1'b0; we = 1'b0; w0 = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; datA = a; datB = b;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (wr_en || write_r0) strobe_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i - 1;
                    r = result; c = carry; z = zero; we = wr_en; w0 = write_r0;
                end
            end
            if (inj[i]) begin
                start = 1'b1; op = OP_ADD; datA = 8'h01; datB = 8'h01;
            end else begin
                start = 1'b0; datA = 8'h33; datB = 8'h77;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = OP_ADD; datA = 8'h00; datB = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, wr_en, write_r0, carry, zero, result} !== 14'h0000) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b we=%b r0=%b c=%b z=%b res=%h, want all 0",
                     busy, done, wr_en, write_r0, carry, zero, result);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_cycle();
        vec_t tbl [8];
        int da, dc, bc, sc;
        logic [7:0] r;
        logic c, z, we, w0;
        tbl = '{'{OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 4'd0},
                '{OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0, 4'd0},
                '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b1, 4'd0},
                '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b1, 4'd0},
                '{OP_OR,  8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b1, 4'd0},
                '{OP_SHL, 8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0},
                '{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0},
                '{OP_SUB, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0}};
        for (int k = 0; k < 8; k++) begin
            run_op(tbl[k].op, tbl[k].a, tbl[k].b, 16'h0000, da, dc, bc, sc, r, c, z, we, w0);
            checks++;
            if (r !== tbl[k].res) begin
                errors++;
                $display("FAIL single%0d_result: got %h want %h", k, r, tbl[k].res);
            end
            checks++;
            if ({c, z} !== {tbl[k].c, tbl[k].z}) begin
                errors++;
                $display("FAIL single%0d_flags: got c=%b z=%b want c=%b z=%b", k, c, z, tbl[k].c, tbl[k].z);
            end
            checks++;
            if (we !== !tbl[k].r0 || w0 !== tbl[k].r0 || sc != 1) begin
                errors++;
                $display("FAIL single%0d_strobe: got we=%b r0=%b cycles=%0d want we=%b r0=%b cycles=1",
                         k, we, w0, sc, !tbl[k].r0, tbl[k].r0);
            end
            checks++;
            if (da != int'(tbl[k].lat) || dc != 1 || bc != int'(tbl[k].lat) + 1) begin
                errors++;
                $display("FAIL single%0d_timing: got lat=%0d dones=%0d busy=%0d want lat=%0d dones=1 busy=%0d",
                         k, da, dc, bc, tbl[k].lat, int'(tbl[k].lat) + 1);
            end
            checks++;
            if (result !== tbl[k].res) begin
                errors++;
                $display("FAIL single%0d_hold: got %h want %h", k, result, tbl[k].res);
            end
        end
    endtask

    task automatic test_iterative();
        vec_t tbl [7];
        int da, dc, bc, sc;
        logic [7:0] r;
        logic c, z, we, w0;
        tbl = '{'{OP_SHL, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 4'd3},
                '{OP_SHR, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 4'd1},
                '{OP_SHR, 8'hC0, 8'h07, 8'h01, 1'b1, 1'b0, 1'b0, 4'd7},
                '{OP_SHL, 8'h01, 8'hFF, 8'h80, 1'b0, 1'b0, 1'b0, 4'd7},
                '{OP_MUL, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b0, 4'd8},
                '{OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 4'd8},
                '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 4'd8}};
        for (int k = 0; k < 7; k++) begin
            run_op(tbl[k].op, tbl[k].a, tbl[k].b, 16'h0000, da, dc, bc, sc, r, c, z, we, w0);
            checks++;
            if (r !== tbl[k].res) begin
                errors++;
                $display("FAIL iter%0d_result: got %h want %h", k, r, tbl[k].res);
            end
            checks++;
            if ({c, z} !== {tbl[k].c, tbl[k].z}) begin
                errors++;
                $display("FAIL iter%0d_flags: got c=%b z=%b want c=%b z=%b", k, c, z, tbl[k].c, tbl[k].z);
            end
            checks++;
            if (we !== 1'b1 || w0 !== 1'b0 || sc != 1) begin
                errors++;
                $display("FAIL iter%0d_strobe: got we=%b r0=%b cycles=%0d want we=1 r0=0 cycles=1",
                         k, we, w0, sc);
            end
            checks++;
            if (da != int'(tbl[k].lat) || dc != 1 || bc != int'(tbl[k].lat) + 1) begin
                errors++;
                $display("FAIL iter%0d_timing: got lat=%0d dones=%0d busy=%0d want lat=%0d dones=1 busy=%0d",
                         k, da, dc, bc, tbl[k].lat, int'(tbl[k].lat) + 1);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int da, dc, bc, sc;
        logic [7:0] r;
        logic c, z, we, w0;
        run_op(OP_MUL, 8'h0D, 8'h0B, 16'h0208, da, dc, bc, sc, r, c, z, we, w0);
        checks++;
        if (dc != 1 || sc != 1 || da != 8) begin
            errors++;
            $display("FAIL busy_start_dones: got dones=%0d strobes=%0d lat=%0d want 1 1 8", dc, sc, da);
        end
        checks++;
        if (r !== 8'h8F || result !== 8'h8F) begin
            errors++;
            $display("FAIL busy_start_result: got %h/%h want 8f", r, result);
        end
    endtask

    task automatic test_reset_mid_op();
        int da, dc, bc, sc, spurious;
        logic [7:0] r;
        logic c, z, we, w0;
        run_op(OP_ADD, 8'hF0, 8'h20, 16'h0000, da, dc, bc, sc, r, c, z, we, w0);
        checks++;
        if ({result, carry} !== {8'h10, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_pre: got res=%h c=%b want 10 1", result, carry);
        end
        @(negedge clk);
        start = 1'b1; op = OP_MUL; datA = 8'h0D; datB = 8'h0B;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, wr_en, write_r0, carry, zero, result} !== 14'h0000) begin
            errors++;
            $display("FAIL rstmid_state: got busy=%b done=%b we=%b r0=%b c=%b z=%b res=%h, want all 0",
                     busy, done, wr_en, write_r0, carry, zero, result);
        end
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || wr_en || write_r0 || busy) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: got %0d active cycles want 0", spurious);
        end
        run_op(OP_ADD, 8'h12, 8'h34, 16'h0000, da, dc, bc, sc, r, c, z, we, w0);
        checks++;
        if ({r, c, z, we} !== {8'h46, 1'b0, 1'b0, 1'b1} || da != 0 || dc != 1) begin
            errors++;
            $display("FAIL rstmid_fresh: got res=%h c=%b z=%b we=%b lat=%0d dones=%0d want 46 0 0 1 0 1",
                     r, c, z, we, da, dc);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        logic [7:0] r1, r5;
        pat = 6'b0; r1 = 8'h00; r5 = 8'h00;
        @(negedge clk);
        start = 1'b1; op = OP_ADD; datA = 8'h01; datB = 8'h01;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            pat[i-1] = done;
            if (i == 1) r1 = result;
            if (i == 5) r5 = result;
            datA = 8'(i);
        end
        start = 1'b0;
        checks++;
        if (pat !== 6'b010101) begin
            errors++;
            $display("FAIL b2b_pattern: got %b want 010101", pat);
        end
        checks++;
        if (r1 !== 8'h02 || r5 !== 8'h05) begin
            errors++;
            $display("FAIL b2b_results: got %h,%h want 02,05", r1, r5);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_cycle();
        test_iterative();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Sequential 8-bit execute unit sitting directly downstream of the register file. It consumes the two read ports (A and B operands) and produces the write-back byte plus the write strobes (general write enable and R0-write) that drive the register file on completion. Single-cycle ops (add, sub, logical) finish in one clock. Shifts and multiply iterate one bit per clock under a small FSM with a start/busy/done handshake.

## Interface
- No parameters; data width fixed at 8.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- datA  input  8  operand A, from register file read port A.
- datB  input  8  operand B, from read port B; for SHL/SHR only datB[2:0] is used as the shift amount.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  8  write-back data; holds its value until the next completion.
- wr_en  output  1  write-back strobe for ADD/SUB/SHL/SHR/MUL, coincident with done.
- write_r0  output  1  R0-write strobe for AND/OR/XOR, coincident with done.
- carry  output  1  flag register, updated only at completion.
- zero  output  1  flag register, high when the result is 0x00; updated only at completion.

## Operation
- FSM states: IDLE, RUN, DONE.
- **Start latch:** on a clock edge with start=1 in IDLE, op, datA and datB are latched. Later operand changes have no effect.
- **Single-cycle ops (ADD/SUB/AND/OR/XOR, SHL/SHR with amount 0):** the result is computed and registered at the start edge, and the FSM goes IDLE→DONE.
- **SHL/SHR with amount n in 1..7:** IDLE→RUN with count=n. Each RUN edge shifts by one bit and decrements count; the edge that makes count 0 moves to DONE.
- **MUL (shift-add, 8 iterations, low byte kept):** IDLE→RUN with count=8. One iteration per edge; the 8th iteration moves to DONE.
- **DONE:** lasts exactly one cycle. done=1 and exactly one of wr_en/write_r0 is 1. The next edge returns to IDLE.
- start is ignored in RUN and DONE; there is no queueing. The maximum issue rate is one op every 2 cycles.
- **Arithmetic and flag rules:**
  - ADD: result = (A+B) mod 256; carry = bit 8 of the 9-bit sum.
  - SUB: result = (A−B) mod 256; carry = 1 iff A<B (borrow).
  - AND/OR/XOR: carry cleared to 0.
  - SHL/SHR: zero-fill; carry = the last bit shifted out. Amount 0 gives result = A and carry = 0.
  - MUL: result = (A·B)[7:0]; carry = 1 iff (A·B)[15:8] ≠ 0.
  - zero = (result == 0) for every op.
- **Reset (any state, including mid-RUN):** FSM→IDLE. busy, done, wr_en, write_r0, carry and zero go to 0; result goes to 0x00. An aborted op produces no done and no strobes.
- reset has priority over start on the same edge.

## Timing
- Let edge k be the edge at which start is accepted.
- Single-cycle ops: done, strobe and new result/flags are visible in the cycle after edge k (latency 1); busy is high for that one cycle.
- Shift by n≥1: done is visible after edge k+n; busy is high for n+1 cycles.
- MUL: done is visible after edge k+8; busy is high for 9 cycles.
- result, carry and zero change only on the edge entering DONE (or on reset). They are stable in the DONE cycle, so the register file captures result on the edge leaving DONE.
- The earliest next accepted start is the edge leaving DONE+1 (IDLE). A start asserted during the DONE cycle is dropped.

## Test plan
- **ADD/SUB:** ADD A=0xF0, B=0x20 → one cycle later result=0x10, carry=1, zero=0, wr_en=1 and write_r0=0 for one cycle. SUB A=0x05, B=0x07 → result=0xFE, carry=1.
- **XOR:** A=0xAA, B=0xAA → result=0x00, zero=1, carry=0, write_r0=1, wr_en=0.
- **MUL:** A=13, B=11 → done exactly 8 cycles after the start edge, result=0x8F, carry=0, busy high for 9 cycles. A=0x10, B=0x10 → result=0x00, carry=1, zero=1.
- **Shifts:**
  - SHL A=0x81, B=0x03 → done after 3 cycles, result=0x08, carry=0.
  - SHR A=0x81, B=0x01 → result=0x40, carry=1.
  - SHL A=0x5A, B=0x08 (amount 0) → single-cycle, result=0x5A, carry=0.
- **Start while busy:** start a MUL, then pulse start with ADD at cycles 3 and 9 (the DONE cycle) → both are ignored; only one done and the MUL result appear.
- **Reset mid-op:** assert reset during the 4th RUN cycle of a MUL → next cycle busy=0, result=0x00, flags=0, and no done or strobe ever appears; a fresh ADD issued afterwards completes normally.
